// File: rtl/run_sequencer.sv
// Run sequencer for the 9-bit core: pulses Start, waits for Ack or a cycle limit,
// counts RUN cycles and hands the single data-memory port to the host or the core.
module run_sequencer #(
    parameter int          AW           = 8,
    parameter int          DW           = 8,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'd4096
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          go,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_start,
    input  logic          core_ack,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [15:0]   cycle_count
);

    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_TOUT  = 3'd4
    } state_t;

    state_t         state_q;
    logic [SCW-1:0] start_cnt_q;
    logic [15:0]    cycle_count_q;
    logic           core_start_q;
    logic           busy_q;
    logic           done_q;
    logic           timeout_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            start_cnt_q   <= '0;
            cycle_count_q <= '0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_TOUT: begin
                    if (go) begin
                        state_q       <= S_START;
                        start_cnt_q   <= '0;
                        cycle_count_q <= '0;
                        core_start_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                    end
                end
                // Ack is not looked at here: it still reflects the previous program.
                S_START: begin
                    if (start_cnt_q == START_LAST) begin
                        state_q      <= S_RUN;
                        core_start_q <= 1'b0;
                    end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cycle_count_q != TIMEOUT) begin
                        cycle_count_q <= cycle_count_q + 16'd1;
                    end
                    if (core_ack) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (cycle_count_q == TIMEOUT - 16'd1) begin
                        state_q   <= S_TOUT;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_start_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Port ownership follows the registered state, so a go cycle still serves the host.
    logic core_owns;

    always_comb begin
        core_owns = (state_q == S_START) || (state_q == S_RUN);
        host_gnt  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        if (core_owns) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else begin
            host_gnt = host_req;
            mem_we   = host_req & host_we;
        end
    end

    assign host_rdata  = mem_rdata;
    assign core_rdata  = mem_rdata;
    assign core_start  = core_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: host accesses and run outcomes are queued as
// expectations by the stimulus and retired by a negedge monitor.
module tb_run_sequencer;

    localparam int          START_CYCLES = 2;
    localparam logic [15:0] TIMEOUT      = 16'd100;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        go = 1'b0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_gnt;
    logic [7:0]  host_rdata;
    logic        core_we = 1'b0;
    logic [7:0]  core_addr = '0;
    logic [7:0]  core_wdata = '0;
    logic [7:0]  core_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        core_start;
    logic        core_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    run_sequencer #(
        .AW(8), .DW(8), .START_CYCLES(START_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .go(go),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_start(core_start),
        .core_ack(core_ack), .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 Clk = ~Clk;

    // Data memory with asynchronous read, synchronous write.
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge Clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        logic       gnt;
        logic       we;
        logic [7:0] addr;
        logic       chk_rd;
        logic [7:0] rd;
    } host_exp_t;

    typedef struct {
        logic        dn;
        logic        to;
        logic [15:0] cnt;
    } run_exp_t;

    host_exp_t hq[$];
    run_exp_t  rq[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: retires host expectations on host_req, run expectations on done/timeout rise.
    logic end_prev = 1'b0;
    int   start_len = 0;
    always @(negedge Clk) begin
        if (Reset) begin
            if (host_req) begin
                if (hq.size() == 0) begin
                    chk("host_unexpected", 16'd1, 16'd0);
                end else begin
                    host_exp_t h;
                    h = hq.pop_front();
                    chk("host_gnt", {15'd0, host_gnt}, {15'd0, h.gnt});
                    chk("mem_we", {15'd0, mem_we}, {15'd0, h.we});
                    chk("mem_addr", {8'd0, mem_addr}, {8'd0, h.addr});
                    if (h.chk_rd) chk("host_rdata", {8'd0, host_rdata}, {8'd0, h.rd});
                    $display("host access addr=%02h gnt=%0b we=%0b rdata=%02h",
                             mem_addr, host_gnt, mem_we, host_rdata);
                end
            end
            if ((done | timeout) && !end_prev) begin
                if (rq.size() == 0) begin
                    chk("run_unexpected", 16'd1, 16'd0);
                end else begin
                    run_exp_t r;
                    r = rq.pop_front();
                    chk("done", {15'd0, done}, {15'd0, r.dn});
                    chk("timeout", {15'd0, timeout}, {15'd0, r.to});
                    chk("cycle_count", cycle_count, r.cnt);
                    chk("busy_after_run", {15'd0, busy}, 16'd0);
                    $display("run end done=%0b timeout=%0b cycle_count=%0d",
                             done, timeout, cycle_count);
                end
            end
            if (core_start) begin
                start_len++;
                chk("busy_in_start", {15'd0, busy}, 16'd1);
            end else if (start_len != 0) begin
                chk("start_len", 16'(start_len), 16'(START_CYCLES));
                $display("start pulse %0d cycles", start_len);
                start_len = 0;
            end
        end
        end_prev = done | timeout;
    end

    task automatic host_cycle(input logic we, input logic [7:0] addr, input logic [7:0] data,
                              input logic exp_gnt, input logic exp_we, input logic [7:0] exp_addr,
                              input logic chk_rd, input logic [7:0] exp_rd);
        host_exp_t h;
        h.gnt = exp_gnt; h.we = exp_we; h.addr = exp_addr; h.chk_rd = chk_rd; h.rd = exp_rd;
        hq.push_back(h);
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
        @(posedge Clk); #1;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic wait_run();
        int i;
        for (i = 0; i < 20 && !(busy && !core_start); i++) begin
            @(posedge Clk); #1;
        end
        if (!(busy && !core_start)) chk("wait_run_expired", 16'd1, 16'd0);
    endtask

    task automatic wait_end();
        int i;
        for (i = 0; i < 300 && !(done || timeout); i++) begin
            @(posedge Clk); #1;
        end
        if (!(done || timeout)) chk("wait_end_expired", 16'd1, 16'd0);
        core_ack = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic push_run(input logic dn, input logic to, input logic [15:0] cnt);
        run_exp_t r;
        r.dn = dn; r.to = to; r.cnt = cnt;
        rq.push_back(r);
    endtask

    // ack_delay < 0 means the core never acknowledges.
    task automatic do_run(input int ack_delay, input logic dn, input logic to,
                          input logic [15:0] cnt);
        push_run(dn, to, cnt);
        go = 1'b1;
        @(posedge Clk); #1;
        go = 1'b0;
        wait_run();
        if (ack_delay >= 0) begin
            repeat (ack_delay) @(posedge Clk);
            #1 core_ack = 1'b1;
        end
        wait_end();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_core_start", {15'd0, core_start}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_timeout", {15'd0, timeout}, 16'd0);
        chk("rst_cycle_count", cycle_count, 16'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;

        // Host preload, then read back.
        host_cycle(1'b1, 8'h10, 8'hA5, 1'b1, 1'b1, 8'h10, 1'b0, 8'h00);
        host_cycle(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 1'b1, 8'hA5);

        // Normal run; go shares its cycle with a host write, which must complete.
        push_run(1'b1, 1'b0, 16'd38);
        go = 1'b1;
        host_cycle(1'b1, 8'h30, 8'h3C, 1'b1, 1'b1, 8'h30, 1'b0, 8'h00);
        go = 1'b0;
        wait_run();
        core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h5A;
        host_cycle(1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00);
        core_we = 1'b0; core_addr = 8'h40;
        host_cycle(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 8'h00);
        go = 1'b1;
        repeat (35) @(posedge Clk);
        #1 core_ack = 1'b1;
        go = 1'b0;
        wait_end();

        host_cycle(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 1'b1, 8'hA5);
        host_cycle(1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h20, 1'b1, 8'h5A);
        host_cycle(1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h30, 1'b1, 8'h3C);

        // Stale ack held through START: finishes after the first RUN cycle.
        core_ack = 1'b1;
        do_run(-1, 1'b1, 1'b0, 16'd1);

        do_run(-1, 1'b0, 1'b1, 16'd100);
        do_run(99, 1'b1, 1'b0, 16'd100);

        // Reset at RUN cycle 20.
        go = 1'b1;
        @(posedge Clk); #1;
        go = 1'b0;
        wait_run();
        repeat (20) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_count_before", cycle_count, 16'd0);
        chk("midrst_core_start", {15'd0, core_start}, 16'd0);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        host_cycle(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 1'b1, 8'hA5);
        do_run(5, 1'b1, 1'b0, 16'd6);

        repeat (3) @(posedge Clk);
        chk("host_queue_empty", 16'(hq.size()), 16'd0);
        chk("run_queue_empty", 16'(rq.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Sequences one program run of the 9-bit core: host preloads data memory, pulses the core's Start, waits for Ack, and reports done or timeout.
- Owns the single data-memory port and switches it between the host loader and the core.
- Counts executed cycles so the host can read the run length.
- Sits between the testbench/host interface and the processor's Start/Ack pins and DataMem port.

Parameters:
- AW, 8, data-memory address width.
- DW, 8, data-memory data width.
- START_CYCLES, 2, number of cycles core_start is held high (minimum 1).
- TIMEOUT, 16'd4096, RUN-state cycle limit before the run is aborted.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset.
- go  in  1  request a new run; sampled in IDLE/DONE/TOUT only.
- host_req  in  1  host memory access request.
- host_we  in  1  host write enable.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_gnt  out  1  host access accepted this cycle.
- host_rdata  out  DW  read data to host.
- core_we  in  1  core write enable.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core write data.
- core_rdata  out  DW  read data to core.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  AW  data-memory address.
- mem_wdata  out  DW  data-memory write data.
- mem_rdata  in  DW  data-memory read data.
- core_start  out  1  drives processor Start.
- core_ack  in  1  processor Ack (done flag).
- busy  out  1  high in START and RUN.
- done  out  1  high in DONE.
- timeout  out  1  high in TOUT.
- cycle_count  out  16  RUN cycles of the current/last run.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, start counter=0, cycle_count=0, core_start=0, busy=0, done=0, timeout=0. Outputs hold these values while Reset=0.
- States: IDLE, START, RUN, DONE, TOUT.
- IDLE/DONE/TOUT, go=1: next state START; cycle_count cleared to 0; done and timeout cleared on entry to START.
- START: core_start=1 for exactly START_CYCLES cycles, then RUN. core_ack is ignored in START, because Ack reflects a stale instruction before Start takes effect.
- RUN: core_start=0. cycle_count increments by 1 every RUN cycle, including the cycle in which ack is seen.
- RUN, core_ack=1: next state DONE.
- RUN, cycle_count==TIMEOUT-1 with core_ack=0: next state TOUT. cycle_count saturates at TIMEOUT.
- RUN, ack and timeout in the same cycle: ack wins; next state DONE.
- DONE/TOUT: hold cycle_count and the done/timeout flag until next go or reset.
- go while busy=1: ignored; no restart.
- Memory arbitration (combinational mux, no added latency):
  - START/RUN: core owns the port. mem_*=core_*, host_gnt=0, host writes dropped.
  - IDLE/DONE/TOUT: host owns the port. host_gnt=host_req, mem_we=host_req&host_we, mem_addr=host_addr, mem_wdata=host_wdata. core_we is ignored.
  - Ownership follows the registered state: the cycle that samples go still belongs to the host, and that host access completes.
- host_rdata and core_rdata both equal mem_rdata at all times. Read latency is whatever DataMem provides; the sequencer adds none.
- mem_we is never asserted by both sources in one cycle.
- Reset mid-run: immediate IDLE, core_start dropped, memory port returned to the host.

Test Plan:
- Host preload: Reset released; host writes 8'hA5 to addr 8'h10, then reads addr 8'h10 -> host_gnt=1 both cycles, mem_we=1 on the write only, host_rdata=8'hA5.
- Normal run: go pulse; core raises ack 37 cycles into RUN -> core_start high 2 cycles, busy high, then done=1 and cycle_count=38, memory port back to host.
- Host blocked during run: in RUN, host_req=1, host_we=1 to addr 8'h10 with 8'h00 -> host_gnt=0, mem_we follows core_we only, addr 8'h10 still reads 8'hA5 after the run.
- Stale ack: core_ack held 1 throughout START -> state reaches RUN anyway; done asserts only after the first RUN cycle with ack=1.
- Timeout with TIMEOUT=100 and ack never raised -> after 100 RUN cycles timeout=1, done=0, cycle_count=100. Ack and timeout in the same cycle -> done=1, timeout=0.
- Reset mid-run: assert Reset=0 at RUN cycle 20 -> core_start=0, busy=0, cycle_count=0 asynchronously. A new go after release starts a clean run.
